// File: rtl/btb_bimodal_predictor_if.sv
// Fetch/execute-side bus of the BTB + bimodal direction predictor.
// master = pipeline, slave = predictor.
interface btb_bimodal_predictor_if #(
    parameter int PERF_BITS = 32
);
    logic [31:0]          current_pc;
    logic                 is_branch;
    logic                 is_rv32c;
    logic [12:0]          imm_sb;
    logic                 predict_taken;
    logic [31:0]          target_addr;
    logic                 btb_hit;
    logic                 update_predictor;
    logic [31:0]          pc_to_update;
    logic [31:0]          update_addr;
    logic                 branch_result;
    logic                 prediction;
    logic                 flush;
    logic [PERF_BITS-1:0] mispredict_count;

    modport master (
        output current_pc, is_branch, is_rv32c, imm_sb,
        output update_predictor, pc_to_update, update_addr, branch_result, prediction, flush,
        input  predict_taken, target_addr, btb_hit, mispredict_count
    );

    modport slave (
        input  current_pc, is_branch, is_rv32c, imm_sb,
        input  update_predictor, pc_to_update, update_addr, branch_result, prediction, flush,
        output predict_taken, target_addr, btb_hit, mispredict_count
    );
endinterface

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, zero-latency
// lookup, registered resolve-time update, flush and saturating mispredict count.
module btb_bimodal_predictor #(
    parameter int NENTRIES        = 64,
    parameter int CNT_BITS        = 2,
    parameter int TAG_BITS        = 16,
    parameter int RV32C_EN        = 1,
    parameter int STATIC_FALLBACK = 1,
    parameter int PERF_BITS       = 32
) (
    input logic                     CLK,
    input logic                     RST,
    btb_bimodal_predictor_if.slave  bus
);
    localparam int IDXW    = $clog2(NENTRIES);
    localparam int IDX_LSB = (RV32C_EN != 0) ? 1 : 2;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

    logic [NENTRIES-1:0]                valid_w;
    logic [NENTRIES-1:0][TAG_BITS-1:0]  tag_w;
    logic [NENTRIES-1:0][31:0]          tgt_w;
    logic [NENTRIES-1:0][CNT_BITS-1:0]  cnt_w;
    logic [PERF_BITS-1:0]               miss_cnt_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.current_pc, bus.pc_to_update};

    // Lookup
    logic [IDXW-1:0]     l_idx;
    logic [TAG_BITS-1:0] l_tag;
    logic                l_hit, l_msb, fb_taken;
    logic [31:0]         imm_sext;

    assign l_idx    = bus.current_pc[IDX_LSB +: IDXW];
    assign l_tag    = bus.current_pc[IDX_LSB + IDXW +: TAG_BITS];
    assign l_hit    = valid_w[l_idx] && (tag_w[l_idx] == l_tag);
    assign l_msb    = cnt_w[l_idx][CNT_BITS-1];
    assign fb_taken = (STATIC_FALLBACK != 0) && bus.is_branch && !l_hit && bus.imm_sb[12];
    assign imm_sext = {{19{bus.imm_sb[12]}}, bus.imm_sb};

    assign bus.btb_hit       = l_hit;
    assign bus.predict_taken = bus.is_branch && (l_hit ? l_msb : fb_taken);

    always_comb begin
        bus.target_addr = bus.current_pc + (bus.is_rv32c ? 32'd2 : 32'd4);
        if (l_hit && l_msb)
            bus.target_addr = tgt_w[l_idx];
        else if (fb_taken)
            bus.target_addr = bus.current_pc + imm_sext;
    end

    // Update side: hit is judged against pre-update state of the addressed entry
    logic [IDXW-1:0]     u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;

    assign u_idx = bus.pc_to_update[IDX_LSB +: IDXW];
    assign u_tag = bus.pc_to_update[IDX_LSB + IDXW +: TAG_BITS];
    assign u_hit = valid_w[u_idx] && (tag_w[u_idx] == u_tag);

    for (genvar e = 0; e < NENTRIES; e++) begin : g_ent
        logic                vld_q;
        logic [TAG_BITS-1:0] tag_q;
        logic [31:0]         tgt_q;
        logic [CNT_BITS-1:0] cnt_q;
        logic                sel;

        assign sel        = bus.update_predictor && (u_idx == IDXW'(e));
        assign valid_w[e] = vld_q;
        assign tag_w[e]   = tag_q;
        assign tgt_w[e]   = tgt_q;
        assign cnt_w[e]   = cnt_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                vld_q <= 1'b0;
                tag_q <= '0;
                tgt_q <= '0;
                cnt_q <= CNT_WNT;
            end else if (bus.flush) begin
                vld_q <= 1'b0;
            end else if (sel) begin
                if (u_hit) begin
                    if (bus.branch_result) begin
                        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_BITS'(1);
                        tgt_q <= bus.update_addr;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_BITS'(1);
                    end
                end else if (bus.branch_result) begin
                    vld_q <= 1'b1;
                    tag_q <= u_tag;
                    tgt_q <= bus.update_addr;
                    cnt_q <= CNT_WT;
                end
            end
        end
    end

    // Mispredicts are counted even when a concurrent flush drops the update
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            miss_cnt_q <= '0;
        else if (bus.update_predictor && (bus.prediction != bus.branch_result) && (miss_cnt_q != '1))
            miss_cnt_q <= miss_cnt_q + PERF_BITS'(1);
    end

    assign bus.mispredict_count = miss_cnt_q;
endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Scoreboard bench: two predictor configs driven in lockstep; expectations are
// queued with the stimulus and checked at the following negedge.
module tb_btb_bimodal_predictor;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    btb_bimodal_predictor_if #(.PERF_BITS(32)) bus_a ();
    btb_bimodal_predictor_if #(.PERF_BITS(2))  bus_b ();

    btb_bimodal_predictor #(
        .NENTRIES(64), .CNT_BITS(2), .TAG_BITS(16), .RV32C_EN(1),
        .STATIC_FALLBACK(1), .PERF_BITS(32)
    ) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));

    btb_bimodal_predictor #(
        .NENTRIES(64), .CNT_BITS(2), .TAG_BITS(16), .RV32C_EN(1),
        .STATIC_FALLBACK(0), .PERF_BITS(2)
    ) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0:       return {31'b0, bus_a.predict_taken};
            1:       return {31'b0, bus_a.btb_hit};
            2:       return bus_a.target_addr;
            3:       return bus_a.mispredict_count;
            4:       return {31'b0, bus_b.predict_taken};
            5:       return {31'b0, bus_b.btb_hit};
            6:       return bus_b.target_addr;
            default: return {30'b0, bus_b.mispredict_count};
        endcase
    endfunction

    task automatic push(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n; e.sel = sel; e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_a(input string n, input logic t, input logic h, input logic [31:0] tgt);
        push({n, "_taken"}, 0, {31'b0, t});
        push({n, "_hit"},   1, {31'b0, h});
        push({n, "_tgt"},   2, tgt);
    endtask

    task automatic exp_b(input string n, input logic t, input logic h, input logic [31:0] tgt);
        push({n, "_b_taken"}, 4, {31'b0, t});
        push({n, "_b_hit"},   5, {31'b0, h});
        push({n, "_b_tgt"},   6, tgt);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, probe(e.sel), e.val);
        end
    endtask

    // Invariant between tasks: time sits 1 unit after a posedge
    task automatic step();
        @(negedge CLK);
        drain();
        @(posedge CLK);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic br, input logic c, input logic [12:0] imm);
        bus_a.current_pc = pc; bus_a.is_branch = br; bus_a.is_rv32c = c; bus_a.imm_sb = imm;
        bus_b.current_pc = pc; bus_b.is_branch = br; bus_b.is_rv32c = c; bus_b.imm_sb = imm;
    endtask

    task automatic set_up(input logic en, input logic [31:0] pc, input logic [31:0] addr,
                          input logic res, input logic pred, input logic fl);
        bus_a.update_predictor = en; bus_a.pc_to_update = pc; bus_a.update_addr = addr;
        bus_a.branch_result = res; bus_a.prediction = pred; bus_a.flush = fl;
        bus_b.update_predictor = en; bus_b.pc_to_update = pc; bus_b.update_addr = addr;
        bus_b.branch_result = res; bus_b.prediction = pred; bus_b.flush = fl;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] addr, input logic res, input logic pred);
        set_up(1'b1, pc, addr, res, pred, 1'b0);
        step();
        set_up(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        look('0, 1'b0, 1'b0, '0);
        set_up(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;

        // Reset state and sequential targets
        look(32'h100, 1'b1, 1'b0, 13'h8);
        exp_a("rst_seq", 1'b0, 1'b0, 32'h104);
        exp_b("rst_seq", 1'b0, 1'b0, 32'h104);
        push("rst_cnt_a", 3, 32'd0);
        push("rst_cnt_b", 7, 32'd0);
        step();
        look(32'h100, 1'b1, 1'b1, 13'h8);
        exp_a("rst_rvc", 1'b0, 1'b0, 32'h102);
        step();
        RST = 1'b0;

        // Static backward fallback on a miss (A has it, B does not)
        look(32'h200, 1'b1, 1'b0, 13'h1FF0);
        exp_a("fb_back", 1'b1, 1'b0, 32'h1F0);
        exp_b("nofb_back", 1'b0, 1'b0, 32'h204);
        step();
        look(32'h200, 1'b0, 1'b0, 13'h1FF0);
        exp_a("not_branch", 1'b0, 1'b0, 32'h204);
        step();

        // Allocation and counter saturation
        upd(32'h100, 32'h400, 1'b1, 1'b1);
        look(32'h100, 1'b1, 1'b0, 13'h8);
        exp_a("alloc", 1'b1, 1'b1, 32'h400);
        step();
        upd(32'h100, 32'h0, 1'b0, 1'b0);
        upd(32'h100, 32'h0, 1'b0, 1'b0);
        exp_a("nt2", 1'b0, 1'b1, 32'h104);
        step();
        upd(32'h100, 32'h0, 1'b0, 1'b0);
        upd(32'h100, 32'h400, 1'b1, 1'b1);
        exp_a("floor", 1'b0, 1'b1, 32'h104);
        step();
        upd(32'h100, 32'h400, 1'b1, 1'b1);
        exp_a("rise", 1'b1, 1'b1, 32'h400);
        step();
        for (int i = 0; i < 4; i++) upd(32'h100, 32'h400, 1'b1, 1'b1);
        upd(32'h100, 32'h0, 1'b0, 1'b0);
        exp_a("sat_top", 1'b1, 1'b1, 32'h400);
        step();
        upd(32'h100, 32'h0, 1'b0, 1'b0);
        exp_a("down", 1'b0, 1'b1, 32'h104);
        step();
        upd(32'h100, 32'h440, 1'b1, 1'b1);
        exp_a("tgt_upd", 1'b1, 1'b1, 32'h440);
        step();
        look(32'h100, 1'b0, 1'b0, 13'h8);
        exp_a("hit_nobr", 1'b0, 1'b1, 32'h440);
        step();

        // Aliasing on index 0: 0x100 tag 2, 0x180 tag 3, 0x300 tag 6
        upd(32'h180, 32'h800, 1'b1, 1'b1);
        look(32'h100, 1'b1, 1'b0, 13'h8);
        exp_a("alias_old", 1'b0, 1'b0, 32'h104);
        exp_b("alias_old", 1'b0, 1'b0, 32'h104);
        step();
        look(32'h180, 1'b1, 1'b0, 13'h8);
        exp_a("alias_new", 1'b1, 1'b1, 32'h800);
        step();
        upd(32'h300, 32'h900, 1'b0, 1'b0);
        exp_a("nt_miss_keep", 1'b1, 1'b1, 32'h800);
        step();
        look(32'h300, 1'b1, 1'b0, 13'h8);
        exp_a("nt_miss_300", 1'b0, 1'b0, 32'h304);
        step();
        upd(32'h180, 32'h0, 1'b0, 1'b0);
        look(32'h180, 1'b1, 1'b0, 13'h8);
        exp_a("weak_taken", 1'b0, 1'b1, 32'h184);
        step();

        // Same-cycle lookup/update shows pre-update state
        upd(32'h100, 32'h400, 1'b1, 1'b1);
        set_up(1'b1, 32'h100, 32'h500, 1'b1, 1'b1, 1'b0);
        look(32'h100, 1'b1, 1'b0, 13'h8);
        exp_a("same_cyc", 1'b1, 1'b1, 32'h400);
        step();
        set_up(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        exp_a("post_upd", 1'b1, 1'b1, 32'h500);
        step();

        // Flush beats a concurrent (mispredicted) update
        set_up(1'b1, 32'h180, 32'hA00, 1'b1, 1'b0, 1'b1);
        step();
        set_up(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        exp_a("flush_old", 1'b0, 1'b0, 32'h104);
        push("flush_cnt_a", 3, 32'd1);
        push("flush_cnt_b", 7, 32'd1);
        step();
        look(32'h180, 1'b1, 1'b0, 13'h8);
        exp_a("flush_drop", 1'b0, 1'b0, 32'h184);
        step();

        // Mispredict counting, saturation on B, async reset mid-update
        upd(32'h100, 32'h400, 1'b1, 1'b1);
        look(32'h100, 1'b1, 1'b0, 13'h8);
        exp_a("pre_rst", 1'b1, 1'b1, 32'h400);
        step();
        for (int i = 0; i < 5; i++) upd(32'h300, 32'h0, 1'b0, 1'b1);
        push("mp_cnt_a", 3, 32'd6);
        push("mp_sat_b", 7, 32'd3);
        step();
        set_up(1'b1, 32'h300, 32'h0, 1'b0, 1'b1, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        push("async_cnt_a", 3, 32'd0);
        push("async_cnt_b", 7, 32'd0);
        exp_a("async_rst", 1'b0, 1'b0, 32'h104);
        drain();
        @(posedge CLK);
        #1;
        set_up(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        look(32'h200, 1'b1, 1'b0, 13'h1FF0);
        exp_a("post_rst_fb", 1'b1, 1'b0, 32'h1F0);
        exp_b("post_rst_fb", 1'b0, 1'b0, 32'h204);
        push("post_rst_cnt_a", 3, 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
